// File: rtl/event_blinker.sv
// Event-to-blink stretcher: each rising edge on trig becomes an ON_CYCLES-long
// high pulse on out, followed by a GAP_CYCLES low gap; extra events are queued.
module event_blinker #(
   parameter int ON_CYCLES  = 3_300_000,
   parameter int GAP_CYCLES = 3_300_000,
   parameter int CNT_W      = 22,
   parameter int PEND_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trig,
   input  logic              clr,
   output logic              out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TIMER_ONE = CNT_W'(1);
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   state_t            state;
   logic [CNT_W-1:0]  timer;
   logic              trig_q;
   logic              trig_edge;
   logic              gap_end;
   logic              pend_full;
   logic              pend_zero;

   // A clear in the same cycle swallows the edge, so it never starts or queues a blink.
   assign trig_edge = trig & ~trig_q & ~clr;
   assign gap_end   = (state == GAP) && (timer == GAP_LAST);
   assign pend_full = (pending == PEND_MAX);
   assign pend_zero = (pending == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         timer    <= '0;
         trig_q   <= 1'b0;
         out      <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         trig_q   <= trig;
         overflow <= 1'b0;

         // The final gap clock consumes either the new edge or one queued event.
         if (clr) begin
            pending <= '0;
         end else if (gap_end) begin
            if (!trig_edge && !pend_zero)
               pending <= pending - PEND_ONE;
         end else if ((state != IDLE) && trig_edge) begin
            if (pend_full)
               overflow <= 1'b1;
            else
               pending <= pending + PEND_ONE;
         end

         case (state)
            IDLE: begin
               if (trig_edge) begin
                  state <= ON;
                  timer <= '0;
                  out   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            ON: begin
               if (timer == ON_LAST) begin
                  state <= GAP;
                  timer <= '0;
                  out   <= 1'b0;
               end else begin
                  timer <= timer + TIMER_ONE;
               end
            end
            GAP: begin
               if (gap_end) begin
                  timer <= '0;
                  if (trig_edge || (!pend_zero && !clr)) begin
                     state <= ON;
                     out   <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  timer <= timer + TIMER_ONE;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
               out   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
